// File: rtl/nxn_board_pkg.sv
// Shared codes for the N x N K-in-a-row board: game states, symbols, scan directions, FSM states.
package nxn_board_pkg;

  localparam logic [1:0] GS_ON   = 2'b00;
  localparam logic [1:0] GS_XWIN = 2'b01;
  localparam logic [1:0] GS_OWIN = 2'b10;
  localparam logic [1:0] GS_DRAW = 2'b11;

  localparam logic SYM_X = 1'b1;
  localparam logic SYM_O = 1'b0;

  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_e;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_e;

  // Flat cell index from 1-based coordinates; caller guarantees the cell is on the board.
  function automatic int cell_idx(int r, int c, int n);
    return (r - 1) * n + (c - 1);
  endfunction

endpackage

// File: rtl/nxn_board_line_scan.sv
// Direction/offset walker: visits the 2K-1 cells through the origin along H, V, D and A lines.
module nxn_board_line_scan
  import nxn_board_pkg::*;
#(
  parameter int N = 3,
  parameter int K = N,
  localparam int CW = $clog2(N + 1),
  localparam int SW = CW + 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 step,
  input  logic [CW-1:0]        org_row,
  input  logic [CW-1:0]        org_col,
  output logic signed [SW-1:0] scan_row,
  output logic signed [SW-1:0] scan_col,
  output logic                 in_board,
  output logic                 dir_first,
  output logic                 last_step
);

  // Two guard bits keep coordinates up to N+K-1 and down to 2-K from aliasing.
  localparam logic signed [SW-1:0] KM1 = SW'(K - 1);
  localparam logic signed [SW-1:0] NS  = SW'(N);
  localparam logic signed [SW-1:0] ONE = SW'(1);

  dir_e                 dir;
  logic signed [SW-1:0] off;
  logic signed [SW-1:0] org_r;
  logic signed [SW-1:0] org_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir   <= DIR_H;
      off   <= '0;
      org_r <= '0;
      org_c <= '0;
    end else if (start) begin
      dir   <= DIR_H;
      off   <= -KM1;
      org_r <= {2'b00, org_row};
      org_c <= {2'b00, org_col};
    end else if (step) begin
      if (off == KM1) begin
        off <= -KM1;
        dir <= dir_e'(dir + 2'd1);
      end else begin
        off <= off + ONE;
      end
    end
  end

  always_comb begin
    scan_row = org_r;
    scan_col = org_c;
    case (dir)
      DIR_H: scan_col = org_c + off;
      DIR_V: scan_row = org_r + off;
      DIR_D: begin
        scan_row = org_r + off;
        scan_col = org_c + off;
      end
      DIR_A: begin
        scan_row = org_r + off;
        scan_col = org_c - off;
      end
    endcase
  end

  assign in_board  = (scan_row >= ONE) && (scan_row <= NS) &&
                     (scan_col >= ONE) && (scan_col <= NS);
  assign dir_first = (off == -KM1);
  assign last_step = (dir == DIR_A) && (off == KM1);

endmodule

// File: rtl/nxn_board.sv
// N x N K-in-a-row board: validates alternating X/O moves, then scans the placed cell's lines for a win or draw.
module nxn_board
  import nxn_board_pkg::*;
#(
  parameter int N = 3,
  parameter int K = N,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          set,
  input  logic [CW-1:0] row,
  input  logic [CW-1:0] col,
  output logic          busy,
  output logic          move_err,
  output logic          turn,
  output logic [N*N-1:0] valid,
  output logic [N*N-1:0] symbol,
  output logic [1:0]    game_state
);

  localparam int NN   = N * N;
  localparam int IW   = $clog2(NN);
  localparam int CNTW = $clog2(NN + 1);
  localparam int RW   = $clog2(K + 1);
  localparam int SW   = CW + 2;

  localparam logic [CW-1:0]   N_C  = CW'(N);
  localparam logic [CNTW-1:0] NN_C = CNTW'(NN);
  localparam logic [RW-1:0]   K_C  = RW'(K);

  if (N < 3 || N > 15 || K < 3 || K > N) begin : g_param_err
    $error("nxn_board: N=%0d K=%0d out of range", N, K);
  end

  state_e               state, state_nxt;
  logic [CNTW-1:0]      moves;
  logic [RW-1:0]        run, run_base, run_nxt;
  logic                 win;
  logic                 in_rng, legal, accept, hit;
  logic                 scan_in, dir_first, last_step;
  logic [IW-1:0]        move_idx, scan_idx;
  logic signed [SW-1:0] scan_row, scan_col;

  assign busy     = (state != S_IDLE);
  assign in_rng   = (row != '0) && (row <= N_C) && (col != '0) && (col <= N_C);
  assign move_idx = IW'(cell_idx(int'(row), int'(col), N));
  assign legal    = in_rng && !valid[move_idx] && (game_state == GS_ON);
  assign accept   = (state == S_IDLE) && set && !clear && legal;

  nxn_board_line_scan #(.N(N), .K(K)) u_scan (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (accept),
    .step     (state == S_CHECK),
    .org_row  (row),
    .org_col  (col),
    .scan_row (scan_row),
    .scan_col (scan_col),
    .in_board (scan_in),
    .dir_first(dir_first),
    .last_step(last_step)
  );

  // A run continues only through on-board cells owned by the player who just moved.
  assign scan_idx = IW'(cell_idx(int'(scan_row), int'(scan_col), N));
  assign hit      = scan_in && valid[scan_idx] && (symbol[scan_idx] == turn);
  assign run_base = dir_first ? '0 : run;
  assign run_nxt  = hit ? run_base + RW'(1) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CHECK;
      S_CHECK: if (run_nxt == K_C || last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      valid      <= '0;
      symbol     <= '0;
      game_state <= GS_ON;
      turn       <= SYM_X;
      move_err   <= 1'b0;
      moves      <= '0;
      run        <= '0;
      win        <= 1'b0;
    end else if (clear) begin
      state      <= S_IDLE;
      valid      <= '0;
      symbol     <= '0;
      game_state <= GS_ON;
      turn       <= SYM_X;
      move_err   <= 1'b0;
      moves      <= '0;
      run        <= '0;
      win        <= 1'b0;
    end else begin
      state    <= state_nxt;
      move_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (set) begin
            if (legal) begin
              valid[move_idx]  <= 1'b1;
              symbol[move_idx] <= turn;
              moves            <= moves + CNTW'(1);
              win              <= 1'b0;
            end else begin
              move_err <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          run <= run_nxt;
          if (run_nxt == K_C) win <= 1'b1;
        end
        S_DONE: begin
          // Win outranks draw on the last cell; turn freezes once the game is over.
          if (win)                game_state <= (turn == SYM_X) ? GS_XWIN : GS_OWIN;
          else if (moves == NN_C) game_state <= GS_DRAW;
          else                    turn <= (turn == SYM_X) ? SYM_O : SYM_X;
        end
        default: ;
      endcase
    end
  end

endmodule
